// File: rtl/actf_bwd.sv
`default_nettype none
// ============================================================================
// Module   : actf_bwd
// Purpose  : Sigmoid backward stage. Given the stored forward activation
//            a = sigmoid(z) and the back-propagated error e, it produces the
//            local gradient delta = e * a * (1 - a) in signed fixed point.
//            A single signed multiplier is shared over two multiply steps.
//            Each step's result is shifted right by frac and saturated.
// Ports    : clk       - clock, rising edge
//            reset     - asynchronous active-high reset
//            en        - global enable; low freezes all state
//            in_valid  - a_in / err_in valid
//            in_ready  - unit can accept an operand pair (IDLE only)
//            a_in      - signed forward activation (Q(DWIDTH-frac).frac)
//            err_in    - signed back-propagated error
//            out_valid - result valid (HOLD state)
//            out_ready - downstream accepts the result
//            out       - signed delta
//            sat       - some multiply step clipped for this result
// Revision : 1.0 - initial release
// ============================================================================
module actf_bwd #(
  parameter int DWIDTH = 32,
  parameter int frac   = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] a_in,
  input  logic signed [DWIDTH-1:0] err_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] out,
  output logic                     sat
);

  // The product is kept two bits wider than 2*DWIDTH. This covers the
  // DWIDTH x (DWIDTH+1) first multiply with room to spare.
  localparam int PW = 2 * DWIDTH + 2;

  localparam logic signed [DWIDTH:0] ONE = {{DWIDTH{1'b0}}, 1'b1} << frac;

  localparam logic signed [PW-1:0] MAXV = {{(PW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [DWIDTH-1:0]  a_q, a_d;
  logic signed [DWIDTH-1:0]  err_q, err_d;
  logic signed [DWIDTH:0]    om_q, om_d;
  logic signed [DWIDTH-1:0]  r1_q, r1_d;
  logic                      clip_q, clip_d;
  logic signed [DWIDTH-1:0]  out_q, out_d;
  logic                      sat_q, sat_d;

  // Shared multiplier. MUL1 computes a*(1-a). MUL2 computes r1*err.
  logic signed [DWIDTH:0]    mul_a, mul_b;
  logic signed [PW-1:0]      prod, prod_sh;
  logic signed [DWIDTH-1:0]  mul_res;
  logic                      mul_clip;

  always_comb begin
    if (state_q == MUL2) begin
      mul_a = {r1_q[DWIDTH-1], r1_q};
      mul_b = {err_q[DWIDTH-1], err_q};
    end else begin
      mul_a = {a_q[DWIDTH-1], a_q};
      mul_b = om_q;
    end
    prod    = PW'(mul_a) * PW'(mul_b);
    // The arithmetic shift rounds toward -inf. Clipping compares the full
    // shifted value, so exactly -2^(DWIDTH-1) is representable and does not clip.
    prod_sh = prod >>> frac;
    if (prod_sh > MAXV) begin
      mul_res  = {1'b0, {(DWIDTH-1){1'b1}}};
      mul_clip = 1'b1;
    end else if (prod_sh < MINV) begin
      mul_res  = {1'b1, {(DWIDTH-1){1'b0}}};
      mul_clip = 1'b1;
    end else begin
      mul_res  = prod_sh[DWIDTH-1:0];
      mul_clip = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    err_d   = err_q;
    om_d    = om_q;
    r1_d    = r1_q;
    clip_d  = clip_q;
    out_d   = out_q;
    sat_d   = sat_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d     = a_in;
            err_d   = err_in;
            om_d    = ONE - {a_in[DWIDTH-1], a_in};
            clip_d  = 1'b0;
            state_d = MUL1;
          end
        end
        MUL1: begin
          r1_d    = mul_res;
          clip_d  = mul_clip;
          state_d = MUL2;
        end
        MUL2: begin
          out_d   = mul_res;
          sat_d   = clip_q | mul_clip;
          state_d = HOLD;
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      err_q   <= '0;
      om_q    <= '0;
      r1_q    <= '0;
      clip_q  <= 1'b0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      err_q   <= err_d;
      om_q    <= om_d;
      r1_q    <= r1_d;
      clip_q  <= clip_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  // The FSM is already IDLE while reset is asserted. Gating keeps in_ready low
  // until reset is released.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == HOLD);
  assign out       = out_q;
  assign sat       = sat_q;

endmodule
`default_nettype wire
